// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and the dump FSM state type used by the
// end-of-program memory dump logic.
package cpu_pkg;

  // Data memory geometry seen by the dump unit.
  localparam int DMEM_DEPTH   = 512;
  localparam int DMEM_ADDR_W  = 9;
  localparam int DATA_W       = 32;

  // Cycles allowed after reset for the program to signal finish.
  localparam int DUMP_TIMEOUT = 300;

  // Dump sequencer states.
  typedef enum logic [2:0] {
    DUMP_IDLE = 3'd0,  // program running, watchdog counting
    DUMP_HALT = 3'd1,  // CPU frozen, last writeback retiring
    DUMP_READ = 3'd2,  // single-cycle read strobe to data memory
    DUMP_WAIT = 3'd3,  // waiting out the memory read latency
    DUMP_SEND = 3'd4,  // word presented on the dump stream
    DUMP_DONE = 3'd5   // dump finished or watchdog expired
  } dump_state_e;

  // Width of a counter that must hold values 0..max_val-1 (never below 1 bit).
  function automatic int cnt_width(input int max_val);
    if (max_val > 1) begin
      return $clog2(max_val);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/dump_watchdog.sv
// Saturating cycle counter that flags a program which never reaches finish.
// Counts only while enabled and holds once the limit has been reached.
module dump_watchdog #(
  parameter int LIMIT = cpu_pkg::DUMP_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic count_en,
  output logic expired
);
  import cpu_pkg::*;

  localparam int               CNT_W   = cnt_width(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, stopping at the expiry value so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count_en && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_MAX);

endmodule

// File: rtl/mem_dump_unit.sv
// End-of-program memory dump: on the CPU finish edge, freeze the pipeline,
// read every data-memory word once and stream it out on a valid/ready port.
// A watchdog ends the run without a dump if finish never arrives.
module mem_dump_unit #(
  parameter int DEPTH   = cpu_pkg::DMEM_DEPTH,
  parameter int ADDR_W  = cpu_pkg::DMEM_ADDR_W,
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = cpu_pkg::DUMP_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              finish,
  output logic              cpu_halt,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  output logic              done,
  output logic              timeout
);
  import cpu_pkg::*;

  localparam int                WAIT_W    = cnt_width(RD_LAT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dump_state_e       state;
  dump_state_e       state_next;
  logic              finish_q;
  logic              start;
  logic              wd_expired;
  logic              wd_count_en;
  logic              handshake;
  logic              wait_last;
  logic              at_last;
  logic [ADDR_W-1:0] addr;
  logic [WAIT_W-1:0] wait_cnt;

  // A rising finish starts the dump; finish_q resets low so a level that is
  // already high on the first cycle after reset also counts as a start.
  assign start       = finish & ~finish_q;
  assign handshake   = dump_valid & dump_ready;
  assign at_last     = (addr == LAST_ADDR);
  assign wait_last   = (wait_cnt == WAIT_LAST);
  assign wd_count_en = (state == DUMP_IDLE);

  // The address counter is a register, so it drives the read port directly.
  assign mem_addr = addr;

  dump_watchdog #(
    .LIMIT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_en (wd_count_en),
    .expired  (wd_expired)
  );

  // Next-state decode for the dump sequencer; start has priority over expiry.
  always_comb begin
    state_next = state;
    case (state)
      DUMP_IDLE: begin
        if (start) begin
          state_next = DUMP_HALT;
        end else if (wd_expired) begin
          state_next = DUMP_DONE;
        end else begin
          state_next = DUMP_IDLE;
        end
      end
      DUMP_HALT: begin
        state_next = DUMP_READ;
      end
      DUMP_READ: begin
        state_next = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        if (wait_last) begin
          state_next = DUMP_SEND;
        end else begin
          state_next = DUMP_WAIT;
        end
      end
      DUMP_SEND: begin
        if (handshake && at_last) begin
          state_next = DUMP_DONE;
        end else if (handshake) begin
          state_next = DUMP_READ;
        end else begin
          state_next = DUMP_SEND;
        end
      end
      DUMP_DONE: begin
        state_next = DUMP_DONE;
      end
      default: begin
        state_next = DUMP_IDLE;
      end
    endcase
  end

  // Sequencer state plus the status/strobe outputs, registered from the
  // next state so each output lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= DUMP_IDLE;
      finish_q   <= 1'b0;
      cpu_halt   <= 1'b0;
      mem_re     <= 1'b0;
      dump_valid <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      finish_q   <= finish;
      mem_re     <= (state_next == DUMP_READ);
      dump_valid <= (state_next == DUMP_SEND);
      done       <= (state_next == DUMP_DONE);
      // Halt is raised only by a real start; the timeout path leaves the CPU free.
      if ((state == DUMP_IDLE) && start) begin
        cpu_halt <= 1'b1;
      end
      if ((state == DUMP_IDLE) && !start && wd_expired) begin
        timeout <= 1'b1;
      end
    end
  end

  // Read-latency counter: runs only in WAIT and clears on the capture cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == DUMP_WAIT) begin
      if (wait_last) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Word address: advances once per accepted word and stops at the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (handshake && !at_last) begin
      addr <= addr + ADDR_W'(1);
    end
  end

  // Output word register: loaded when read data lands, held through any
  // backpressure; the last flag drops once the final word is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dump_addr <= '0;
      dump_data <= '0;
      dump_last <= 1'b0;
    end else if ((state == DUMP_WAIT) && wait_last) begin
      dump_addr <= addr;
      dump_data <= mem_rdata;
      dump_last <= at_last;
    end else if (handshake) begin
      dump_last <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Bench for mem_dump_unit: two instances (read latency 1 and 2) driven by
// directed sequences, checked every cycle against a cycle-count model.
module tb_mem_dump_unit;
  localparam int DEPTH   = 512;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 300;
  localparam int LAT0    = 1;
  localparam int LAT1    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n0, finish0, cpu_halt0, mem_re0, dump_valid0, dump_ready0, dump_last0, done0, timeout0;
  logic [ADDR_W-1:0] mem_addr0, dump_addr0;
  logic [DATA_W-1:0] mem_rdata0, dump_data0;
  logic              rst_n1, finish1, cpu_halt1, mem_re1, dump_valid1, dump_ready1, dump_last1, done1, timeout1;
  logic [ADDR_W-1:0] mem_addr1, dump_addr1;
  logic [DATA_W-1:0] mem_rdata1, dump_data1, pipe1;

  mem_dump_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT0), .TIMEOUT(TIMEOUT)) u_dut0 (
    .clk(clk), .rst_n(rst_n0), .finish(finish0), .cpu_halt(cpu_halt0), .mem_re(mem_re0),
    .mem_addr(mem_addr0), .mem_rdata(mem_rdata0), .dump_valid(dump_valid0), .dump_ready(dump_ready0),
    .dump_addr(dump_addr0), .dump_data(dump_data0), .dump_last(dump_last0), .done(done0), .timeout(timeout0));

  mem_dump_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(LAT1), .TIMEOUT(TIMEOUT)) u_dut1 (
    .clk(clk), .rst_n(rst_n1), .finish(finish1), .cpu_halt(cpu_halt1), .mem_re(mem_re1),
    .mem_addr(mem_addr1), .mem_rdata(mem_rdata1), .dump_valid(dump_valid1), .dump_ready(dump_ready1),
    .dump_addr(dump_addr1), .dump_data(dump_data1), .dump_last(dump_last1), .done(done1), .timeout(timeout1));

  // Memory contents: instance 0 holds i*4, instance 1 a distinct pattern.
  function automatic logic [31:0] word_of(input int k, input int a);
    if (k == 0) return 32'(a * 4);
    else return 32'hA500_0000 + 32'(a * 3);
  endfunction

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem0[i] = word_of(0, i);
      mem1[i] = word_of(1, i);
    end
    mem_rdata0 = 32'h0;
    mem_rdata1 = 32'h0;
    pipe1 = 32'h0;
  end

  // Data memories; non-read cycles return junk so a mistimed capture shows.
  always @(posedge clk) begin
    mem_rdata0 <= mem_re0 ? mem0[mem_addr0] : 32'hDEAD_BEEF;
    pipe1      <= mem_re1 ? mem1[mem_addr1] : 32'hDEAD_BEEF;
    mem_rdata1 <= pipe1;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: phase 0 idle, 1 dumping, 2 finished. gap = edges left until valid.
  int m_phase [2];
  bit m_fin_q [2];
  int m_wd    [2];
  int m_addr  [2];
  int m_gap   [2];
  bit m_valid [2];
  bit m_halt  [2];
  bit m_done  [2];
  bit m_to    [2];
  int m_hs    [2];
  bit chk_en = 1'b0;

  task automatic model_step(input int k, input logic rst, input logic fin, input logic rdy, input int rl);
    bit st;
    if (!rst) begin
      m_phase[k] = 0; m_fin_q[k] = 1'b0; m_wd[k] = 0; m_addr[k] = 0; m_gap[k] = 0;
      m_valid[k] = 1'b0; m_halt[k] = 1'b0; m_done[k] = 1'b0; m_to[k] = 1'b0; m_hs[k] = 0;
    end else begin
      st = fin && !m_fin_q[k];
      m_fin_q[k] = fin;
      if (m_phase[k] == 0) begin
        if (st) begin
          m_phase[k] = 1; m_halt[k] = 1'b1; m_addr[k] = 0; m_gap[k] = 2 + rl;
        end else if (m_wd[k] == TIMEOUT - 1) begin
          m_phase[k] = 2; m_done[k] = 1'b1; m_to[k] = 1'b1;
        end else begin
          m_wd[k]++;
        end
      end else if (m_phase[k] == 1) begin
        if (m_valid[k]) begin
          if (rdy) begin
            m_hs[k]++;
            m_valid[k] = 1'b0;
            if (m_addr[k] == DEPTH - 1) begin
              m_phase[k] = 2; m_done[k] = 1'b1;
            end else begin
              m_addr[k]++; m_gap[k] = 1 + rl;
            end
          end
        end else begin
          m_gap[k]--;
          if (m_gap[k] == 0) m_valid[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp_outputs(input int k, input int rl, input logic halt, input logic re,
                             input logic [ADDR_W-1:0] maddr, input logic v, input logic [ADDR_W-1:0] daddr,
                             input logic [DATA_W-1:0] ddata, input logic dlast, input logic dn, input logic to);
    bit exp_re;
    string p;
    p = $sformatf("u%0d.", k);
    exp_re = (m_phase[k] == 1) && !m_valid[k] && (m_gap[k] == 1 + rl);
    chk({p, "cpu_halt"},   64'(halt), 64'(m_halt[k]));
    chk({p, "mem_re"},     64'(re),   64'(exp_re));
    chk({p, "dump_valid"}, 64'(v),    64'(m_valid[k]));
    chk({p, "done"},       64'(dn),   64'(m_done[k]));
    chk({p, "timeout"},    64'(to),   64'(m_to[k]));
    if (exp_re) chk({p, "mem_addr"}, 64'(maddr), 64'(m_addr[k]));
    if (m_valid[k]) begin
      chk({p, "dump_addr"}, 64'(daddr), 64'(m_addr[k]));
      chk({p, "dump_data"}, 64'(ddata), 64'(word_of(k, m_addr[k])));
      chk({p, "dump_last"}, 64'(dlast), 64'(m_addr[k] == DEPTH - 1));
    end
    if (m_phase[k] == 0) begin
      chk({p, "idle_mem_addr"},  64'(maddr), 64'd0);
      chk({p, "idle_dump_addr"}, 64'(daddr), 64'd0);
      chk({p, "idle_dump_data"}, 64'(ddata), 64'd0);
      chk({p, "idle_dump_last"}, 64'(dlast), 64'd0);
    end
  endtask

  // Advance the model on the same edge the DUTs use.
  always @(posedge clk) begin
    model_step(0, rst_n0, finish0, dump_ready0, LAT0);
    model_step(1, rst_n1, finish1, dump_ready1, LAT1);
    chk_en <= 1'b1;
  end

  int hs0 = 0, last0 = 0, re_seen0 = 0, hs1 = 0;
  logic [DATA_W-1:0] last_data0 = '0, last_data1 = '0;

  // Compare every cycle on the falling edge and tally observed handshakes.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_outputs(0, LAT0, cpu_halt0, mem_re0, mem_addr0, dump_valid0, dump_addr0, dump_data0, dump_last0, done0, timeout0);
      cmp_outputs(1, LAT1, cpu_halt1, mem_re1, mem_addr1, dump_valid1, dump_addr1, dump_data1, dump_last1, done1, timeout1);
    end
    if (!rst_n0) begin
      hs0 = 0; last0 = 0; re_seen0 = 0;
    end else begin
      if (mem_re0) re_seen0++;
      if (dump_valid0 && dump_ready0) begin
        hs0++;
        if (dump_last0) begin last0++; last_data0 = dump_data0; end
      end
    end
    if (!rst_n1) hs1 = 0;
    else if (dump_valid1 && dump_ready1) begin
      hs1++;
      if (dump_last1) last_data1 = dump_data1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Leaves instance 0 in its first cycle after reset (cycle 0).
  task automatic reset0();
    rst_n0 = 1'b0;
    tick(2);
    rst_n0 = 1'b1;
  endtask

  task automatic wait_done0(input int limit, input string nm);
    int n;
    n = 0;
    while (!done0 && n < limit) begin tick(1); n++; end
    chk(nm, 64'(done0), 64'd1);
  endtask

  initial begin
    int n;
    rst_n0 = 1'b0; rst_n1 = 1'b0; finish0 = 1'b0; finish1 = 1'b0;
    dump_ready0 = 1'b1; dump_ready1 = 1'b1;

    // Test 1: finish pulse at cycle 10, full dump with ready held high.
    reset0();
    chk("t1.rst_halt",  64'(cpu_halt0),   64'd0);
    chk("t1.rst_valid", 64'(dump_valid0), 64'd0);
    chk("t1.rst_done",  64'(done0),       64'd0);
    tick(10);
    finish0 = 1'b1;
    chk("t1.halt_c10", 64'(cpu_halt0), 64'd0);
    tick(1);
    finish0 = 1'b0;
    chk("t1.halt_c11", 64'(cpu_halt0), 64'd1);
    tick(2);
    chk("t1.valid_c13", 64'(dump_valid0), 64'd0);
    tick(1);
    chk("t1.valid_c14", 64'(dump_valid0), 64'd1);
    chk("t1.first_addr", 64'(dump_addr0), 64'd0);
    chk("t1.first_data", 64'(dump_data0), 64'd0);
    wait_done0(3000, "t1.done_reached");
    chk("t1.hs_count",   64'(hs0),        64'd512);
    chk("t1.model_hs",   64'(m_hs[0]),    64'd512);
    chk("t1.last_count", 64'(last0),      64'd1);
    chk("t1.last_data",  64'(last_data0), 64'd2044);
    chk("t1.halt_done",  64'(cpu_halt0),  64'd1);

    // Test 2: finish never arrives; watchdog ends the run at cycle 300.
    reset0();
    tick(299);
    chk("t2.to_c299",   64'(timeout0), 64'd0);
    chk("t2.done_c299", 64'(done0),    64'd0);
    tick(1);
    chk("t2.to_c300",   64'(timeout0), 64'd1);
    chk("t2.done_c300", 64'(done0),    64'd1);
    chk("t2.no_halt",   64'(cpu_halt0), 64'd0);
    chk("t2.no_reads",  64'(re_seen0),  64'd0);
    tick(10);
    chk("t2.to_sticky", 64'(timeout0), 64'd1);

    // Test 3: hold ready low on word 5 for 20 cycles.
    reset0();
    tick(2);
    finish0 = 1'b1;
    tick(1);
    finish0 = 1'b0;
    n = 0;
    while (!(dump_valid0 && dump_addr0 == 9'd4) && n < 100) begin tick(1); n++; end
    chk("t3.reach4", 64'(n < 100), 64'd1);
    tick(1);
    dump_ready0 = 1'b0;
    n = 0;
    while (!dump_valid0 && n < 20) begin tick(1); n++; end
    chk("t3.addr5", 64'(dump_addr0), 64'd5);
    chk("t3.data5", 64'(dump_data0), 64'd20);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t3.stall_valid", 64'(dump_valid0), 64'd1);
      chk("t3.stall_addr",  64'(dump_addr0),  64'd5);
      chk("t3.stall_data",  64'(dump_data0),  64'd20);
      chk("t3.stall_re",    64'(mem_re0),     64'd0);
    end
    dump_ready0 = 1'b1;
    tick(1);
    n = 1;
    while (!dump_valid0 && n < 20) begin tick(1); n++; end
    chk("t3.gap6",  64'(n),          64'd3);
    chk("t3.addr6", 64'(dump_addr0), 64'd6);
    chk("t3.data6", 64'(dump_data0), 64'd24);
    wait_done0(3000, "t3.done_reached");
    chk("t3.hs_count", 64'(hs0), 64'd512);

    // Test 4: finish high through reset release; a later pulse is ignored.
    finish0 = 1'b1;
    reset0();
    wait_done0(3000, "t4.done_reached");
    chk("t4.hs_first", 64'(hs0), 64'd512);
    finish0 = 1'b0;
    tick(5);
    finish0 = 1'b1;
    tick(3);
    finish0 = 1'b0;
    tick(20);
    chk("t4.hs_total", 64'(hs0),         64'd512);
    chk("t4.valid",    64'(dump_valid0), 64'd0);
    chk("t4.done",     64'(done0),       64'd1);

    // Test 5: reset mid-dump at word 100, then restart from address 0.
    reset0();
    tick(2);
    finish0 = 1'b1;
    tick(1);
    finish0 = 1'b0;
    n = 0;
    while (!(dump_valid0 && dump_addr0 == 9'd100) && n < 1000) begin tick(1); n++; end
    chk("t5.reach100", 64'(n < 1000), 64'd1);
    rst_n0 = 1'b0;
    tick(1);
    chk("t5.halt",  64'(cpu_halt0),   64'd0);
    chk("t5.re",    64'(mem_re0),     64'd0);
    chk("t5.maddr", 64'(mem_addr0),   64'd0);
    chk("t5.valid", 64'(dump_valid0), 64'd0);
    chk("t5.daddr", 64'(dump_addr0),  64'd0);
    chk("t5.ddata", 64'(dump_data0),  64'd0);
    chk("t5.last",  64'(dump_last0),  64'd0);
    chk("t5.done",  64'(done0),       64'd0);
    rst_n0 = 1'b1;
    tick(3);
    finish0 = 1'b1;
    tick(1);
    finish0 = 1'b0;
    n = 0;
    while (!dump_valid0 && n < 20) begin tick(1); n++; end
    chk("t5.restart_addr", 64'(dump_addr0), 64'd0);
    chk("t5.restart_data", 64'(dump_data0), 64'd0);
    wait_done0(3000, "t5.done_reached");
    chk("t5.hs_count", 64'(hs0), 64'd512);

    // Test 6: read latency 2 instance; latency 5, spacing 4.
    rst_n1 = 1'b1;
    tick(2);
    finish1 = 1'b1;
    tick(1);
    finish1 = 1'b0;
    n = 1;
    while (!dump_valid1 && n < 50) begin tick(1); n++; end
    chk("t6.first_latency", 64'(n),          64'd5);
    chk("t6.addr0",         64'(dump_addr1), 64'd0);
    chk("t6.data0",         64'(dump_data1), 64'hA500_0000);
    tick(1);
    n = 1;
    while (!dump_valid1 && n < 50) begin tick(1); n++; end
    chk("t6.spacing", 64'(n),          64'd4);
    chk("t6.addr1",   64'(dump_addr1), 64'd1);
    chk("t6.data1",   64'(dump_data1), 64'hA500_0003);
    n = 0;
    while (!done1 && n < 3000) begin tick(1); n++; end
    chk("t6.done_reached", 64'(done1),      64'd1);
    chk("t6.hs_count",     64'(hs1),        64'd512);
    chk("t6.last_data",    64'(last_data1), 64'hA500_05FD);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
